alu_rr_controller: RTL and testbench

- Sequences one R-type (opcode 0110011) instruction at a time through the register-register ALU: decode, register-file read, ALU enable, writeback.
- Sits between the fetch/decode front end and the register file / register-register ALU of the minimal RV32I core.
- Owns the only enable into the register-register ALU.
- Rejects illegal funct7/funct3 combinations without writing the register file.

---
 rtl/rv32i_pkg.sv | 38 +++
 rtl/alu_rr_controller_if.sv | 39 +++
 rtl/rr_decode.sv | 24 ++
 rtl/alu_rr_controller.sv | 120 ++++++++++++
 tb/tb_alu_rr_controller.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: R-type opcode/funct constants, field positions and
// the register-register controller state encoding.
package rv32i_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  localparam logic [OPCODE_W-1:0] OPCODE_OP   = 7'b0110011;
  localparam logic [FUNCT7_W-1:0] FUNCT7_BASE = 7'h00;
  localparam logic [FUNCT7_W-1:0] FUNCT7_ALT  = 7'h20;
  localparam logic [FUNCT3_W-1:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SRL_SRA = 3'b101;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_READ      = 2'd1;
  localparam logic [1:0] ST_EXECUTE   = 2'd2;
  localparam logic [1:0] ST_WRITEBACK = 2'd3;

  typedef struct packed {
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rs1;
    logic [FUNCT3_W-1:0] funct3;
    logic [REG_W-1:0]    rd;
  } rr_fields_t;

endpackage

// File: rtl/alu_rr_controller_if.sv
// Bundle between the R-type controller and its front end, register file and ALU.
// master is the controller side, slave is the surrounding datapath.
interface alu_rr_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instruction;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_value;
  logic [XLEN-1:0] rf_rs2_value;
  logic            alu_enable;
  logic [2:0]      alu_funct3;
  logic [6:0]      alu_funct7;
  logic [XLEN-1:0] alu_rs1_value;
  logic [XLEN-1:0] alu_rs2_value;
  logic [XLEN-1:0] alu_rd_value;
  logic            rf_write_enable;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_value;
  logic            done;
  logic            illegal;
  logic            busy;

  modport master (
    input  instr_valid, instruction, rf_rs1_value, rf_rs2_value, alu_rd_value,
    output instr_ready, rf_rs1_addr, rf_rs2_addr, alu_enable, alu_funct3, alu_funct7,
           alu_rs1_value, alu_rs2_value, rf_write_enable, rf_rd_addr, rf_rd_value,
           done, illegal, busy
  );

  modport slave (
    output instr_valid, instruction, rf_rs1_value, rf_rs2_value, alu_rd_value,
    input  instr_ready, rf_rs1_addr, rf_rs2_addr, alu_enable, alu_funct3, alu_funct7,
           alu_rs1_value, alu_rs2_value, rf_write_enable, rf_rd_addr, rf_rd_value,
           done, illegal, busy
  );
endinterface

// File: rtl/rr_decode.sv
// Field extraction and legality check for an R-type register-register word.
module rr_decode import rv32i_pkg::*; (
  input  logic [INSTR_W-1:0] instruction,
  output rr_fields_t         fields,
  output logic               legal
);

  logic [OPCODE_W-1:0] opcode;

  always_comb begin
    opcode        = instruction[OPCODE_LSB +: OPCODE_W];
    fields.rd     = instruction[RD_LSB     +: REG_W];
    fields.funct3 = instruction[FUNCT3_LSB +: FUNCT3_W];
    fields.rs1    = instruction[RS1_LSB    +: REG_W];
    fields.rs2    = instruction[RS2_LSB    +: REG_W];
    fields.funct7 = instruction[FUNCT7_LSB +: FUNCT7_W];
    // Only SUB and SRA use the alternate funct7 encoding.
    legal = (opcode == OPCODE_OP) &&
            ((fields.funct7 == FUNCT7_BASE) ||
             ((fields.funct7 == FUNCT7_ALT) &&
              ((fields.funct3 == FUNCT3_ADD_SUB) || (fields.funct3 == FUNCT3_SRL_SRA))));
  end

endmodule

// File: rtl/alu_rr_controller.sv
// Sequences one R-type instruction at a time through decode, register read,
// ALU execution and register-file writeback.
module alu_rr_controller import rv32i_pkg::*; #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_rr_controller_if.master  bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  rr_fields_t       dec_fields, instr_q, instr_nx;
  logic             dec_legal;
  logic [XLEN-1:0]  rs1_q, rs1_nx, rs2_q, rs2_nx, rd_val_q, rd_val_nx;
  logic [REG_W-1:0] rd_addr_q, rd_addr_nx;
  logic             alu_en_q, alu_en_nx, we_q, we_nx, done_q, done_nx, ill_q, ill_nx;

  rr_decode u_decode (
    .instruction (bus.instruction),
    .fields      (dec_fields),
    .legal       (dec_legal)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    instr_nx   = instr_q;
    rs1_nx     = rs1_q;
    rs2_nx     = rs2_q;
    rd_addr_nx = rd_addr_q;
    rd_val_nx  = rd_val_q;
    alu_en_nx  = 1'b0;
    we_nx      = 1'b0;
    done_nx    = 1'b0;
    ill_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        // The cycle after a rejection is not a handshake slot.
        if (bus.instr_valid && !ill_q) begin
          if (dec_legal) begin
            instr_nx = dec_fields;
            state_nx = ST_READ;
          end else begin
            ill_nx = 1'b1;
          end
        end
      end
      ST_READ: begin
        rs1_nx    = bus.rf_rs1_value;
        rs2_nx    = bus.rf_rs2_value;
        alu_en_nx = 1'b1;
        cnt_nx    = '0;
        state_nx  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cnt == CNT_LAST) begin
          rd_addr_nx = instr_q.rd;
          rd_val_nx  = bus.alu_rd_value;
          we_nx      = (instr_q.rd != '0);
          done_nx    = 1'b1;
          state_nx   = ST_WRITEBACK;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_WRITEBACK: state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_addr_q <= '0;
      rd_val_q  <= '0;
      alu_en_q  <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      instr_q   <= instr_nx;
      rs1_q     <= rs1_nx;
      rs2_q     <= rs2_nx;
      rd_addr_q <= rd_addr_nx;
      rd_val_q  <= rd_val_nx;
      alu_en_q  <= alu_en_nx;
      we_q      <= we_nx;
      done_q    <= done_nx;
      ill_q     <= ill_nx;
    end
  end

  assign bus.instr_ready     = reset_n & (state == ST_IDLE) & ~ill_q;
  assign bus.busy            = (state != ST_IDLE);
  assign bus.rf_rs1_addr     = instr_q.rs1;
  assign bus.rf_rs2_addr     = instr_q.rs2;
  assign bus.alu_funct3      = instr_q.funct3;
  assign bus.alu_funct7      = instr_q.funct7;
  assign bus.alu_rs1_value   = rs1_q;
  assign bus.alu_rs2_value   = rs2_q;
  assign bus.alu_enable      = alu_en_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_rd_addr      = rd_addr_q;
  assign bus.rf_rd_value     = rd_val_q;
  assign bus.done            = done_q;
  assign bus.illegal         = ill_q;

endmodule

// File: tb/tb_alu_rr_controller.sv
// Randomized bench for two controllers (ALU latency 1 and 3) sharing one
// instruction stream, checked against a transaction-level schedule model.
module tb_alu_rr_controller;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  typedef struct packed {
    logic alu_en, done, ill, we;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] op1, op2, wval;
  } exp_t;

  typedef struct packed {
    logic ready, busy, alu_en, done, ill, we;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] op1, op2, wval;
  } obs_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid   = 1'b0;
  logic [31:0] word    = 32'd0;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] erf [2][32];
  logic [31:0] mrf [2][32];
  logic [31:0] alu_res [2];
  exp_t        sched [2][16];
  int          ready_at [2];
  int          busy_until [2];
  int          age [2];
  int          lat [2];

  always #5 clock = ~clock;

  alu_rr_controller_if #(.XLEN(32)) bus_a ();
  alu_rr_controller_if #(.XLEN(32)) bus_b ();

  alu_rr_controller #(.ALU_LATENCY(LAT_A), .XLEN(32)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  alu_rr_controller #(.ALU_LATENCY(LAT_B), .XLEN(32)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  assign bus_a.instr_valid  = valid;
  assign bus_a.instruction  = word;
  assign bus_b.instr_valid  = valid;
  assign bus_b.instruction  = word;
  assign bus_a.rf_rs1_value = (bus_a.rf_rs1_addr == 5'd0) ? 32'd0 : erf[0][bus_a.rf_rs1_addr];
  assign bus_a.rf_rs2_value = (bus_a.rf_rs2_addr == 5'd0) ? 32'd0 : erf[0][bus_a.rf_rs2_addr];
  assign bus_b.rf_rs1_value = (bus_b.rf_rs1_addr == 5'd0) ? 32'd0 : erf[1][bus_b.rf_rs1_addr];
  assign bus_b.rf_rs2_value = (bus_b.rf_rs2_addr == 5'd0) ? 32'd0 : erf[1][bus_b.rf_rs2_addr];
  assign bus_a.alu_rd_value = alu_res[0];
  assign bus_b.alu_rd_value = alu_res[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return (f7 == 7'h20) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit legal_ref(input logic [31:0] w);
    return (w[6:0] == 7'h33) &&
           ((w[31:25] == 7'h00) || ((w[31:25] == 7'h20) && ((w[14:12] == 3'd0) || (w[14:12] == 3'd5))));
  endfunction

  function automatic logic [31:0] rand_instr();
    int unsigned r;
    logic [6:0] f7, op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    r   = $urandom_range(0, 9);
    rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
    f7  = (r < 5) ? 7'h00 : (r < 8) ? 7'h20 : 7'($urandom);
    op  = (r == 9) ? 7'($urandom) : 7'h33;
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    if (k == 0) begin
      o.ready = bus_a.instr_ready; o.busy = bus_a.busy; o.alu_en = bus_a.alu_enable;
      o.done = bus_a.done; o.ill = bus_a.illegal; o.we = bus_a.rf_write_enable;
      o.rs1 = bus_a.rf_rs1_addr; o.rs2 = bus_a.rf_rs2_addr; o.rd = bus_a.rf_rd_addr;
      o.f3 = bus_a.alu_funct3; o.f7 = bus_a.alu_funct7; o.op1 = bus_a.alu_rs1_value;
      o.op2 = bus_a.alu_rs2_value; o.wval = bus_a.rf_rd_value;
    end else begin
      o.ready = bus_b.instr_ready; o.busy = bus_b.busy; o.alu_en = bus_b.alu_enable;
      o.done = bus_b.done; o.ill = bus_b.illegal; o.we = bus_b.rf_write_enable;
      o.rs1 = bus_b.rf_rs1_addr; o.rs2 = bus_b.rf_rs2_addr; o.rd = bus_b.rf_rd_addr;
      o.f3 = bus_b.alu_funct3; o.f7 = bus_b.alu_funct7; o.op1 = bus_b.alu_rs1_value;
      o.op2 = bus_b.alu_rs2_value; o.wval = bus_b.rf_rd_value;
    end
    return o;
  endfunction

  // Compare one cycle of outputs against the scheduled events for that cycle.
  task automatic model_check(input int k, input obs_t o);
    string p;
    exp_t  e;
    int    s;
    p = $sformatf("L%0d c%0d", lat[k], cyc);
    s = cyc % 16;
    e = sched[k][s];
    check({p, " ready"},   32'(o.ready),  32'(cyc >= ready_at[k]));
    check({p, " busy"},    32'(o.busy),   32'(cyc < busy_until[k]));
    check({p, " alu_en"},  32'(o.alu_en), 32'(e.alu_en));
    check({p, " done"},    32'(o.done),   32'(e.done));
    check({p, " illegal"}, 32'(o.ill),    32'(e.ill));
    check({p, " rf_we"},   32'(o.we),     32'(e.we));
    if (e.alu_en) begin
      check({p, " funct3"}, 32'(o.f3),  32'(e.f3));
      check({p, " funct7"}, 32'(o.f7),  32'(e.f7));
      check({p, " rs1a"},   32'(o.rs1), 32'(e.rs1));
      check({p, " rs2a"},   32'(o.rs2), 32'(e.rs2));
      check({p, " op1"},    o.op1,      e.op1);
      check({p, " op2"},    o.op2,      e.op2);
    end
    if (e.done) begin
      check({p, " rd_addr"}, 32'(o.rd), 32'(e.rd));
      check({p, " rd_val"},  o.wval,    e.wval);
      if (e.we) mrf[k][e.rd] = e.wval;
    end
    sched[k][s] = '0;
  endtask

  // On an accepted instruction, schedule its visible events.
  task automatic accept(input int k);
    exp_t e;
    logic [4:0] rd, rs1, rs2;
    if (!valid || cyc < ready_at[k]) return;
    if (!legal_ref(word)) begin
      sched[k][(cyc + 1) % 16].ill = 1'b1;
      ready_at[k] = cyc + 2;
      return;
    end
    rd = word[11:7]; rs1 = word[19:15]; rs2 = word[24:20];
    e = '0;
    e.alu_en = 1'b1; e.f3 = word[14:12]; e.f7 = word[31:25];
    e.rs1 = rs1; e.rs2 = rs2;
    e.op1 = (rs1 == 5'd0) ? 32'd0 : mrf[k][rs1];
    e.op2 = (rs2 == 5'd0) ? 32'd0 : mrf[k][rs2];
    sched[k][(cyc + 2) % 16] = e;
    e.wval = ref_alu(e.f3, e.f7, e.op1, e.op2);
    e.alu_en = 1'b0; e.done = 1'b1; e.we = (rd != 5'd0); e.rd = rd;
    sched[k][(cyc + 2 + lat[k]) % 16] = e;
    ready_at[k]   = cyc + 3 + lat[k];
    busy_until[k] = cyc + 3 + lat[k];
  endtask

  // Register file write and an ALU whose result is only valid ALU_LATENCY cycles on.
  task automatic env(input int k, input obs_t o);
    if (o.we) erf[k][o.rd] = o.wval;
    if (o.alu_en) age[k] = 1;
    else if (age[k] != 0 && age[k] < 15) age[k]++;
    alu_res[k] = (age[k] == lat[k]) ? ref_alu(o.f3, o.f7, o.op1, o.op2) : $urandom;
  endtask

  task automatic step(input logic v, input logic [31:0] w);
    obs_t oa, ob;
    @(negedge clock);
    cyc++;
    oa = sample(0);
    ob = sample(1);
    model_check(0, oa);
    model_check(1, ob);
    valid = v;
    word  = w;
    accept(0);
    accept(1);
    env(0, oa);
    env(1, ob);
  endtask

  task automatic wait_idle();
    while (cyc < ready_at[0] || cyc < ready_at[1]) step(1'b0, $urandom);
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    for (int k = 0; k < 2; k++) begin
      erf[k][r] = v;
      mrf[k][r] = v;
    end
  endtask

  task automatic reset_check(input string tag);
    for (int k = 0; k < 2; k++) begin
      obs_t o;
      o = sample(k);
      check($sformatf("%s L%0d ready", tag, lat[k]),  32'(o.ready),  32'd0);
      check($sformatf("%s L%0d busy", tag, lat[k]),   32'(o.busy),   32'd0);
      check($sformatf("%s L%0d alu_en", tag, lat[k]), 32'(o.alu_en), 32'd0);
      check($sformatf("%s L%0d rf_we", tag, lat[k]),  32'(o.we),     32'd0);
      check($sformatf("%s L%0d done", tag, lat[k]),   32'(o.done),   32'd0);
      check($sformatf("%s L%0d illegal", tag, lat[k]), 32'(o.ill),   32'd0);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ready_at[k]   = cyc;
      busy_until[k] = cyc;
      age[k]        = 0;
      alu_res[k]    = $urandom;
      for (int i = 0; i < 16; i++) sched[k][i] = '0;
    end
  endtask

  task automatic issue(input logic [31:0] w);
    wait_idle();
    step(1'b1, w);
    step(1'b0, $urandom);
  endtask

  initial begin
    lat[0] = LAT_A;
    lat[1] = LAT_B;
    for (int r = 0; r < 32; r++) set_reg(r, (r == 0) ? 32'd0 : $urandom);
    model_reset();
    #2;
    reset_check("reset");
    check("reset rd_val", bus_b.rf_rd_value, 32'd0);
    check("reset op1", bus_a.alu_rs1_value, 32'd0);
    @(negedge clock);
    cyc++;
    reset_n = 1'b1;
    model_reset();

    // ADD x3,x1,x2 with 5 + 7
    wait_idle();
    set_reg(1, 32'd5); set_reg(2, 32'd7);
    issue(32'h002081B3);
    wait_idle();
    check("add x3 L1", erf[0][3], 32'd12);
    check("add x3 L3", erf[1][3], 32'd12);

    // SUB x5,x6,x7 with 3 - 4
    set_reg(6, 32'd3); set_reg(7, 32'd4);
    issue(32'h407302B3);
    wait_idle();
    check("sub x5 L1", erf[0][5], 32'hFFFF_FFFF);
    check("sub x5 L3", erf[1][5], 32'hFFFF_FFFF);

    // Illegal funct3 with alternate funct7, then the same with OP-IMM opcode
    issue(32'h40001033);
    issue(32'h40001013);
    // ADD x0 completes without a write
    issue(32'h00208033);

    // valid held high, instruction changing while busy
    wait_idle();
    set_reg(1, 32'd5); set_reg(2, 32'd7); set_reg(6, 32'd3); set_reg(7, 32'd4);
    repeat (2)  step(1'b1, 32'h002081B3);
    repeat (10) step(1'b1, 32'h407302B3);
    step(1'b0, $urandom);

    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, rand_instr());

    // Reset while both controllers are executing
    wait_idle();
    set_reg(1, 32'd9); set_reg(2, 32'd10); set_reg(3, 32'd77);
    step(1'b1, 32'h002081B3);
    step(1'b0, $urandom);
    step(1'b0, $urandom);
    #1 reset_n = 1'b0;
    #1 reset_check("rst_exec");
    @(negedge clock);
    cyc++;
    reset_check("rst_hold");
    check("rst no write L1", erf[0][3], 32'd77);
    check("rst no write L3", erf[1][3], 32'd77);
    reset_n = 1'b1;
    valid   = 1'b0;
    model_reset();
    issue(32'h002081B3);
    wait_idle();
    check("post rst add L1", erf[0][3], 32'd19);
    check("post rst add L3", erf[1][3], 32'd19);
    repeat (4) step(1'b0, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
